// File: rtl/switch_display_ctrl_pkg.sv
// rtl/switch_display_ctrl_pkg.sv - shared types, constants and segment encoding for switch_display_ctrl
package switch_display_pkg;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_UPDATE} state_e;
    typedef enum logic {MODE_HEX, MODE_DEC} mode_e;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         BCD_DIGITS = 6;
    localparam int         BCD_W      = 4 * BCD_DIGITS;

    // Active-low, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/switch_display_ctrl_if.sv
// rtl/switch_display_ctrl_if.sv - start/done handshake between the controller and the BCD converter
interface switch_display_ctrl_if
    import switch_display_pkg::*;
#(
    parameter int BIN_WIDTH = 18
);
    logic                 start;
    logic [BIN_WIDTH-1:0] bin;
    logic                 busy;
    logic                 done;
    logic [BCD_W-1:0]     bcd;

    modport master (output start, bin, input busy, done, bcd);
    modport slave  (input start, bin, output busy, done, bcd);
endinterface

// File: rtl/switch_display_ctrl_bin2bcd_seq.sv
// rtl/switch_display_ctrl_bin2bcd_seq.sv - sequential double-dabble binary to BCD converter
module bin2bcd_seq
    import switch_display_pkg::*;
#(
    parameter int BIN_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    switch_display_ctrl_if.slave  conv
);
    localparam int ITER_W = $clog2(BIN_WIDTH + 1);

    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [ITER_W-1:0]    iter_q, iter_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]     work_q, work_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BCD_W-1:0]     adj;
    logic [BCD_W+BIN_WIDTH-1:0] shifted;

    always_comb begin
        adj = work_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        end
        shifted = {adj, bin_q} << 1;

        busy_d = busy_q;
        done_d = 1'b0;
        iter_d = iter_q;
        bin_d  = bin_q;
        work_d = work_q;
        bcd_d  = bcd_q;
        if (busy_q) begin
            bin_d  = shifted[BIN_WIDTH-1:0];
            work_d = shifted[BCD_W+BIN_WIDTH-1:BIN_WIDTH];
            iter_d = iter_q + 1'b1;
            // Publish on the last iteration so bcd only changes together with done.
            if (iter_q == ITER_W'(BIN_WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                bcd_d  = shifted[BCD_W+BIN_WIDTH-1:BIN_WIDTH];
            end
        end else if (conv.start) begin
            busy_d = 1'b1;
            iter_d = '0;
            bin_d  = conv.bin;
            work_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            iter_q <= '0;
            bin_q  <= '0;
            work_q <= '0;
            bcd_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            iter_q <= iter_d;
            bin_q  <= bin_d;
            work_q <= work_d;
            bcd_q  <= bcd_d;
        end
    end

    assign conv.busy = busy_q;
    assign conv.done = done_q;
    assign conv.bcd  = bcd_q;

endmodule

// File: rtl/switch_display_ctrl.sv
// rtl/switch_display_ctrl.sv - debounced switch word shown on eight seven-segment digits in hex or decimal
module switch_display_ctrl
    import switch_display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BIN_WIDTH       = 18
) (
    input  logic                  CLOCK_50_I,
    input  logic                  RESET_I,
    input  logic [BIN_WIDTH-1:0]  SWITCH_I,
    input  logic [3:0]            PUSH_BUTTON_N_I,
    output logic [7:0][6:0]       SEVEN_SEGMENT_N_O,
    output logic [BIN_WIDTH-1:0]  LED_RED_O,
    output logic [8:0]            LED_GREEN_O
);
    localparam int CNT_W      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int HEX_DIGITS = (BIN_WIDTH + 3) / 4;
    localparam int CH_SW      = 0;
    localparam int CH_BTN     = 1;
    // Button channel idles high (released) so reset never looks like a press.
    localparam logic [1:0][BIN_WIDTH-1:0] DB_RST = {BIN_WIDTH'(1), BIN_WIDTH'(0)};

    logic [1:0][BIN_WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0][BIN_WIDTH-1:0] cand_q, cand_d, deb_q, deb_d;
    logic [1:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic                      sw_chg_q, sw_chg_d, mode_tog_q, mode_tog_d;
    mode_e                     mode_q, mode_d, disp_mode_q, disp_mode_d;
    state_e                    state_q, state_d;
    logic                      pending_q, pending_d, retry_q, retry_d;
    logic [BIN_WIDTH-1:0]      word_q, word_d, led_red_q, led_red_d;
    logic [7:0][6:0]           seg_q, seg_d;
    logic                      req;
    logic                      unused_ok;

    switch_display_ctrl_if #(.BIN_WIDTH(BIN_WIDTH)) conv_if ();

    bin2bcd_seq #(.BIN_WIDTH(BIN_WIDTH)) u_bin2bcd (
        .clk  (CLOCK_50_I),
        .rst  (RESET_I),
        .conv (conv_if)
    );

    function automatic logic [7:0][6:0] render(input logic [31:0] digits, input int n);
        logic [7:0][6:0] r;
        logic            seen;
        seen = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            r[i] = SEG_BLANK;
            if (i < n && (seen || digits[4*i +: 4] != 4'd0 || i == 0)) begin
                r[i] = hex_to_seg(digits[4*i +: 4]);
                seen = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        sync1_d[CH_SW]  = SWITCH_I;
        sync1_d[CH_BTN] = BIN_WIDTH'(PUSH_BUTTON_N_I[0]);
        sync2_d         = sync1_q;
        for (int c = 0; c < 2; c++) begin
            cand_d[c] = cand_q[c];
            cnt_d[c]  = cnt_q[c];
            deb_d[c]  = deb_q[c];
            if (sync2_q[c] != cand_q[c]) begin
                cand_d[c] = sync2_q[c];
                cnt_d[c]  = '0;
            end else begin
                if (cnt_q[c] != DEB_MAX) cnt_d[c] = cnt_q[c] + 1'b1;
                if (cnt_d[c] == DEB_MAX) deb_d[c] = cand_q[c];
            end
        end
        sw_chg_d   = (deb_d[CH_SW] != deb_q[CH_SW]);
        mode_tog_d = deb_q[CH_BTN][0] & ~deb_d[CH_BTN][0];
        mode_d     = mode_q;
        if (mode_tog_d) mode_d = (mode_q == MODE_HEX) ? MODE_DEC : MODE_HEX;
        led_red_d  = deb_q[CH_SW];
    end

    // Sequencing: a change pulse and a mode toggle in the same cycle form one request.
    always_comb begin
        req           = sw_chg_q | mode_tog_q;
        state_d       = state_q;
        pending_d     = pending_q;
        retry_d       = 1'b0;
        word_d        = word_q;
        disp_mode_d   = disp_mode_q;
        seg_d         = seg_q;
        conv_if.start = 1'b0;
        conv_if.bin   = deb_q[CH_SW];
        case (state_q)
            S_IDLE: begin
                if (req || retry_q) begin
                    word_d      = deb_q[CH_SW];
                    disp_mode_d = mode_q;
                    if (mode_q == MODE_DEC) begin
                        conv_if.start = 1'b1;
                        state_d       = S_CONVERT;
                    end else begin
                        state_d = S_UPDATE;
                    end
                end
            end
            S_CONVERT: begin
                if (req) pending_d = 1'b1;
                if (conv_if.done) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (disp_mode_q == MODE_DEC) seg_d = render(32'(conv_if.bcd), BCD_DIGITS);
                else                         seg_d = render(32'(word_q), HEX_DIGITS);
                state_d   = S_IDLE;
                retry_d   = pending_q | req;
                pending_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (RESET_I) begin
            sync1_q     <= DB_RST;
            sync2_q     <= DB_RST;
            cand_q      <= DB_RST;
            deb_q       <= DB_RST;
            cnt_q       <= '0;
            sw_chg_q    <= 1'b0;
            mode_tog_q  <= 1'b0;
            mode_q      <= MODE_HEX;
            disp_mode_q <= MODE_HEX;
            state_q     <= S_IDLE;
            pending_q   <= 1'b0;
            retry_q     <= 1'b0;
            word_q      <= '0;
            led_red_q   <= '0;
            seg_q       <= {8{SEG_BLANK}};
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cand_q      <= cand_d;
            deb_q       <= deb_d;
            cnt_q       <= cnt_d;
            sw_chg_q    <= sw_chg_d;
            mode_tog_q  <= mode_tog_d;
            mode_q      <= mode_d;
            disp_mode_q <= disp_mode_d;
            state_q     <= state_d;
            pending_q   <= pending_d;
            retry_q     <= retry_d;
            word_q      <= word_d;
            led_red_q   <= led_red_d;
            seg_q       <= seg_d;
        end
    end

    assign SEVEN_SEGMENT_N_O = seg_q;
    assign LED_RED_O         = led_red_q;
    assign LED_GREEN_O       = {6'b0, pending_q, state_q == S_CONVERT, mode_q == MODE_DEC};
    assign unused_ok         = &{1'b0, PUSH_BUTTON_N_I[3:1], conv_if.busy};

endmodule

// File: tb/tb_switch_display_ctrl.sv
// tb/tb_switch_display_ctrl.sv - randomized self-checking bench for switch_display_ctrl
module tb_switch_display_ctrl;
    localparam int DB = 4;
    localparam logic [55:0] ALL_BLANK = {8{7'h7F}};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [17:0]     sw = '0;
    logic [3:0]      btn_n = 4'hF;
    logic [7:0][6:0] seg;
    logic [17:0]     led_r;
    logic [8:0]      led_g;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    switch_display_ctrl #(.DEBOUNCE_CYCLES(DB), .BIN_WIDTH(18)) dut (
        .CLOCK_50_I        (clk),
        .RESET_I           (rst),
        .SWITCH_I          (sw),
        .PUSH_BUTTON_N_I   (btn_n),
        .SEVEN_SEGMENT_N_O (seg),
        .LED_RED_O         (led_r),
        .LED_GREEN_O       (led_g)
    );

    // Reference: a value is accepted once DB consecutive synchronized samples agree.
    int          cyc = 0;
    logic [17:0] sw_hist[$];
    logic        btn_hist[$];
    logic [17:0] m_sw  = '0;
    logic        m_btn = 1'b1;
    bit          m_dec = 1'b0;
    int          sw_edge = -1;
    int          btn_edge = -1;

    always @(posedge clk) begin
        int  n;
        bit  same;
        cyc = cyc + 1;
        if (rst) begin
            sw_hist.delete();
            btn_hist.delete();
            repeat (DB + 2) begin
                sw_hist.push_back('0);
                btn_hist.push_back(1'b1);
            end
            m_sw  = '0;
            m_btn = 1'b1;
            m_dec = 1'b0;
        end else begin
            sw_hist.push_back(sw);
            btn_hist.push_back(btn_n[0]);
            if (sw_hist.size() > 16) void'(sw_hist.pop_front());
            if (btn_hist.size() > 16) void'(btn_hist.pop_front());
            n = sw_hist.size();
            same = 1'b1;
            for (int k = 3; k <= DB + 2; k++) if (sw_hist[n-k] != sw_hist[n-3]) same = 1'b0;
            if (same && sw_hist[n-3] != m_sw) begin
                m_sw    = sw_hist[n-3];
                sw_edge = cyc;
            end
            same = 1'b1;
            for (int k = 3; k <= DB + 2; k++) if (btn_hist[n-k] != btn_hist[n-3]) same = 1'b0;
            if (same && btn_hist[n-3] != m_btn) begin
                m_btn = btn_hist[n-3];
                if (!m_btn) begin
                    m_dec    = !m_dec;
                    btn_edge = cyc;
                end
            end
        end
    end

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [55:0] exp_disp(input int unsigned val, input bit dec);
        logic [7:0][6:0] r;
        int unsigned     base, pow;
        int              nd;
        base = dec ? 10 : 16;
        nd   = dec ? 6 : 5;
        pow  = 1;
        for (int i = 0; i < 8; i++) begin
            r[i] = 7'h7F;
            if (i < nd && (i == 0 || val / pow != 0)) r[i] = seg_code(4'((val / pow) % base));
            if (i < nd) pow = pow * base;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic wait_sw_edge(output int t);
        int old, lim;
        old = sw_edge;
        lim = cyc + 40;
        while (sw_edge == old && cyc < lim) tick(1);
        if (sw_edge == old) check("sw_debounce_timeout", 64'(0), 64'(1));
        t = sw_edge;
    endtask

    task automatic wait_btn_edge(output int t);
        int old, lim;
        old = btn_edge;
        lim = cyc + 40;
        while (btn_edge == old && cyc < lim) tick(1);
        if (btn_edge == old) check("btn_debounce_timeout", 64'(0), 64'(1));
        t = btn_edge;
    endtask

    task automatic press_button(output int t);
        btn_n[0] = 1'b0;
        wait_btn_edge(t);
        btn_n[0] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, t2, lat;
        logic [17:0] w;

        tick(3);
        check("rst_seg", 64'(seg), 64'(ALL_BLANK));
        check("rst_led_red", 64'(led_r), 64'(0));
        check("rst_led_green", 64'(led_g), 64'(0));
        rst = 1'b0;
        tick(12);
        check("zero_word_seg", 64'(seg), 64'(ALL_BLANK));
        check("zero_word_led_green", 64'(led_g), 64'(0));

        sw = 18'h2ABCD;
        wait_sw_edge(t);
        wait_cyc(t + 1);
        check("hex_led_red", 64'(led_r), 64'(18'h2ABCD));
        check("hex_seg_before", 64'(seg), 64'(ALL_BLANK));
        wait_cyc(t + 2);
        check("hex_seg", 64'(seg), 64'(exp_disp(32'h2ABCD, 1'b0)));

        for (int k = 0; k < 10; k++) begin
            sw = (k % 2 == 0) ? 18'h00001 : 18'h00000;
            tick(2);
            check("bounce_hold", 64'(seg), 64'(exp_disp(32'h2ABCD, 1'b0)));
        end
        sw = 18'h00001;
        wait_sw_edge(t);
        wait_cyc(t + 2);
        check("bounce_final", 64'(seg), 64'(exp_disp(1, 1'b0)));

        sw = 18'd262143;
        wait_sw_edge(t);
        wait_cyc(t + 2);
        check("max_hex", 64'(seg), 64'(exp_disp(262143, 1'b0)));
        btn_n[0] = 1'b0;
        tick(10);
        check("btn_mode_dec", 64'(led_g[0]), 64'(1));
        btn_n[0] = 1'b1;
        t = btn_edge;
        wait_cyc(t + 1);
        check("conv_busy_start", 64'(led_g[1]), 64'(1));
        wait_cyc(t + 19);
        check("conv_busy_end", 64'(led_g[1]), 64'(1));
        wait_cyc(t + 20);
        check("dec_seg_before", 64'(seg), 64'(exp_disp(262143, 1'b0)));
        wait_cyc(t + 21);
        check("dec_seg", 64'(seg), 64'(exp_disp(262143, 1'b1)));
        check("conv_idle", 64'(led_g[1]), 64'(0));

        btn_n[0] = 1'b0;
        wait_btn_edge(t);
        tick(30);
        check("hold_single_toggle", 64'(led_g[0]), 64'(m_dec));
        btn_n[0] = 1'b1;
        tick(30);
        check("release_no_toggle", 64'(led_g[0]), 64'(m_dec));
        if (!m_dec) begin
            press_button(t);
            tick(30);
        end

        sw = 18'd15;
        wait_sw_edge(t);
        tick(3);
        sw = 18'd1000;
        wait_sw_edge(t2);
        wait_cyc(t2 + 1);
        check("pending_set", 64'(led_g[2]), 64'(1));
        wait_cyc(t + 21);
        check("pending_first", 64'(seg), 64'(exp_disp(15, 1'b1)));
        check("pending_clear", 64'(led_g[2]), 64'(0));
        wait_cyc(t + 41);
        check("pending_hold", 64'(seg), 64'(exp_disp(15, 1'b1)));
        wait_cyc(t + 42);
        check("pending_second", 64'(seg), 64'(exp_disp(1000, 1'b1)));
        tick(5);

        for (int k = 0; k < 8; k++) begin
            if (k % 3 == 1) begin
                press_button(t);
                lat = m_dec ? 21 : 2;
                wait_cyc(t + lat);
                check("rnd_btn_mode", 64'(led_g[0]), 64'(m_dec));
                check("rnd_btn_seg", 64'(seg), 64'(exp_disp(m_sw, m_dec)));
            end else begin
                w = 18'($urandom_range(0, 262143));
                if (w == m_sw) w = w ^ 18'h1;
                sw = w;
                wait_sw_edge(t);
                lat = m_dec ? 21 : 2;
                wait_cyc(t + lat);
                check("rnd_led_red", 64'(led_r), 64'(w));
                check("rnd_seg", 64'(seg), 64'(exp_disp(w, m_dec)));
            end
            tick(25);
        end

        if (!m_dec) begin
            press_button(t);
            tick(30);
        end
        w = 18'($urandom_range(1, 262143));
        if (w == m_sw) w = w ^ 18'h2;
        sw = w;
        wait_sw_edge(t);
        wait_cyc(t + 5);
        check("pre_reset_busy", 64'(led_g[1]), 64'(1));
        rst = 1'b1;
        tick(1);
        check("mid_rst_seg", 64'(seg), 64'(ALL_BLANK));
        check("mid_rst_led_red", 64'(led_r), 64'(0));
        check("mid_rst_led_green", 64'(led_g), 64'(0));
        rst = 1'b0;
        wait_sw_edge(t);
        wait_cyc(t + 2);
        check("post_rst_hex", 64'(seg), 64'(exp_disp(w, 1'b0)));
        tick(30);
        check("no_stale_bcd", 64'(seg), 64'(exp_disp(w, 1'b0)));
        check("post_rst_mode", 64'(led_g), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
